skolem_exhaustive_checker: RTL
==============================

Name: skolem_exhaustive_checker

Overview:
- Sequencer that exhaustively sweeps every NUM_IN-bit input assignment into a combinational Skolem-function block and into a golden invertibility-condition oracle.
- Compares the Skolem output against the oracle output for every vector, counts mismatches and records the first failing vector.
- Sits in the bring-up/verification wrapper around the generated SKOLEMFORMULA netlists (for example, the 8-input bvsge/bvashr instances) and owns their input bus.

Parameters:
- NUM_IN, 8, width of the Skolem-function input vector; the sweep covers 2^NUM_IN vectors.
- SETTLE, 0, extra hold cycles per vector before sampling; supports registered or multicycle DUT/oracle paths.
- STOP_FIRST, 0, when 1 the sweep terminates at the first mismatch.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; starts a sweep when in IDLE or DONE.
- abort  in  1  pulse; cancels any activity.
- vec_o  out  NUM_IN  input assignment driven to both DUT and oracle.
- dut_y_i  in  1  Skolem-function output for vec_o.
- gold_y_i  in  1  oracle output for vec_o.
- gold_dc_i  in  1  oracle don't-care; the output is unconstrained for this vector.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; results valid.
- pass  out  1  done and zero mismatches.
- mismatch_cnt  out  NUM_IN+1  number of failing vectors.
- first_fail_valid  out  1  at least one mismatch has been recorded.
- first_fail_vec  out  NUM_IN  vector of the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: vec_o, busy, done, pass, mismatch_cnt, first_fail_*.
- States:
  - IDLE: wait for start.
  - SETTLE: hold vec_o.
  - CHECK: sample and compare.
  - DONE: hold results.
- IDLE/DONE + start (abort=0):
  - Clear all results; vec_o=0; busy=1; done=0; pass=0.
  - Next state is SETTLE with settle counter=SETTLE-1 if SETTLE>0, else CHECK.
- SETTLE: the counter decrements each cycle; at 0 go to CHECK. Inputs are ignored in SETTLE.
- CHECK (exactly one cycle per vector):
  - Mismatch is defined as gold_dc_i=0 and dut_y_i != gold_y_i, sampled at the clock edge ending CHECK.
  - On mismatch: mismatch_cnt++. If first_fail_valid=0, set first_fail_vec=vec_o and first_fail_valid=1.
  - If vec_o is all-ones, or STOP_FIRST=1 and this vector mismatched: go to DONE with busy=0, done=1, and pass=(final count==0). vec_o holds its last value.
  - Otherwise vec_o++ and enter SETTLE (SETTLE>0) or CHECK.
- Timing: each vector takes SETTLE+1 cycles. A full sweep takes 2^NUM_IN*(SETTLE+1) cycles from the start edge to done=1.
- mismatch_cnt width NUM_IN+1 holds the maximum 2^NUM_IN, so there is no saturation logic. vec_o does not wrap; the sweep ends at all-ones.
- start while busy: ignored.
- abort (any state):
  - Next cycle: IDLE, with all outputs cleared as at reset.
  - abort takes priority over a simultaneous start.
- DONE persists, with outputs stable, until start or abort.
- rst_n asserted mid-sweep: immediate clear; the sweep is not resumed.
- gold_dc_i=1 suppresses the compare only; the vector is still consumed.

Decomposition:
- Package skolem_chk_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE).
  - default NUM_IN constant.
  - function computing the mismatch predicate.
- Sub-module skolem_settle_timer:
  - loadable down-counter with load, en, and zero flag.
  - Generated out when SETTLE=0.

Test Plan:
- NUM_IN=8, SETTLE=0, gold_y_i tied to dut_y_i, start pulse -> done=1 exactly 256 cycles later, pass=1, mismatch_cnt=0, vec_o=8'hFF.
- Oracle inverts dut only at vec_o=8'hA5 -> mismatch_cnt=1, first_fail_vec=8'hA5, first_fail_valid=1, pass=0.
- Same as the previous scenario but gold_dc_i=1 at 8'hA5 -> pass=1, mismatch_cnt=0.
- STOP_FIRST=1, mismatches at 8'h10 and 8'h20 -> done on the 17th CHECK, vec_o=8'h10, mismatch_cnt=1, busy=0.
- SETTLE=2:
  - Full sweep takes 768 cycles.
  - dut_y_i forced wrong only during SETTLE cycles -> pass=1.
  - dut_y_i forced wrong during CHECK of 8'h03 -> first_fail_vec=8'h03.
- Interrupts:
  - abort at vec_o=8'h40 -> next cycle IDLE with all outputs 0. A following start gives a normal full sweep with pass=1.
  - rst_n pulsed low mid-sweep -> same cleared outputs asynchronously.
  - start asserted together with abort -> stays IDLE.

Source files
------------

// File: rtl/skolem_chk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skolem_chk_pkg : shared types and helpers for the exhaustive Skolem checker
// Rev 1.0
// ---------------------------------------------------------------------------
package skolem_chk_pkg;

  localparam int DEFAULT_NUM_IN = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } chk_state_e;

  // A don't-care from the oracle leaves the Skolem output unconstrained.
  function automatic logic is_mismatch(input logic dut_y, input logic gold_y,
                                       input logic gold_dc);
    return !gold_dc && (dut_y != gold_y);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skolem_settle_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skolem_settle_timer : loadable down-counter with zero flag (hold per vector)
// Rev 1.0
// ---------------------------------------------------------------------------
module skolem_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/skolem_exhaustive_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skolem_exhaustive_checker : sweeps all input vectors, compares Skolem vs oracle
// Rev 1.0
// ---------------------------------------------------------------------------
module skolem_exhaustive_checker
  import skolem_chk_pkg::*;
#(
  parameter int NUM_IN     = DEFAULT_NUM_IN,
  parameter int SETTLE     = 0,
  parameter int STOP_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_IN-1:0] vec_o,
  input  logic              dut_y_i,
  input  logic              gold_y_i,
  input  logic              gold_dc_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   mismatch_cnt,
  output logic              first_fail_valid,
  output logic [NUM_IN-1:0] first_fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  chk_state_e        state_q, state_d;
  logic [NUM_IN-1:0] vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [NUM_IN:0]   cnt_q, cnt_d;
  logic              ffv_q, ffv_d;
  logic [NUM_IN-1:0] ffvec_q, ffvec_d;

  logic              tmr_load, tmr_en, tmr_zero;
  logic              mm;
  logic [NUM_IN:0]   cnt_final;

  generate
    if (SETTLE > 0) begin : g_timer
      localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
      skolem_settle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .en       (tmr_en),
        .zero     (tmr_zero)
      );
    end else begin : g_no_timer
      logic unused_tmr;
      assign unused_tmr = tmr_load ^ tmr_en;
      assign tmr_zero   = 1'b1;
    end
  endgenerate

  assign mm        = is_mismatch(dut_y_i, gold_y_i, gold_dc_i);
  assign cnt_final = mm ? (cnt_q + (NUM_IN+1)'(1)) : cnt_q;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    cnt_d    = cnt_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          if (SETTLE > 0) begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_CHECK: begin
        cnt_d = cnt_final;
        if (mm && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec_q;
        end
        // The sweep stops at all-ones; vec_o never wraps.
        if ((&vec_q) || ((STOP_FIRST != 0) && mm)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_final == '0);
        end else begin
          vec_d = vec_q + NUM_IN'(1);
          if (SETTLE > 0) begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      vec_d    = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      cnt_d    = '0;
      ffv_d    = 1'b0;
      ffvec_d  = '0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign vec_o            = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
`default_nettype wire
